// File: rtl/c_decode_issue.sv
// ----------------------------------------------------------------------------
// c_decode_issue
//
// Single-entry RV32I decode/issue stage with a RAW scoreboard.
//
// Decodes OP, OP-IMM, LOAD, STORE and LUI into a register-file/ALU bundle. The
// bundle is held in one output register, so an accepted instruction appears on
// the outputs one cycle later. A 32-bit busy vector records destination
// registers whose writeback is still pending. An incoming instruction that
// reads a busy register is held off (hazard=1), unless that register is being
// written back in the same cycle.
//
// Parameters
//   SB_EN      1 enables the scoreboard; 0 ties hazard low
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   instr is valid
//   in_ready   stage accepts instr this cycle
//   instr      32-bit RV32I instruction word
//   wb_valid   writeback of register wb_rd completes this cycle
//   wb_rd      writeback destination index
//   out_valid  decoded bundle is valid
//   out_ready  downstream consumes the bundle
//   rs1/rs2/rd register indices (rs1/rs2 are the raw instruction fields)
//   rw         register-file write enable
//   imm        sign-extended immediate
//   alu_op     ALU operation code
//   illegal    unsupported opcode (the bundle still issues)
//   hazard     incoming instruction is stalled on a busy source register
// ----------------------------------------------------------------------------
module c_decode_issue #(
  parameter bit SB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rw,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic        hazard
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        illegal;
  } bundle_t;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  bundle_t dec;
  logic    use_rs1;
  logic    use_rs2;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    dec.rs1     = rs1_f;
    dec.rs2     = rs2_f;
    dec.rd      = rd_f;
    dec.rw      = 1'b0;
    dec.imm     = '0;
    dec.alu_op  = 4'b0000;
    dec.illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec.alu_op = {instr[30], funct3};
        dec.rw     = (rd_f != 5'd0);
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm    = {{20{instr[31]}}, instr[31:20]};
        // Only the shift-right group carries a variant bit in instr[30];
        // for the others that bit is part of the immediate.
        dec.alu_op = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
        dec.rw     = (rd_f != 5'd0);
        use_rs1    = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = {{20{instr[31]}}, instr[31:20]};
        dec.rw  = (rd_f != 5'd0);
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        dec.imm = {instr[31:12], 12'b0};
        dec.rw  = (rd_f != 5'd0);
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Scoreboard hazard check
  // --------------------------------------------------------------------------
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        src1_stall;
  logic        src2_stall;
  logic        wb_hit1;
  logic        wb_hit2;

  // A writeback landing this cycle releases its register immediately.
  assign wb_hit1    = wb_valid && (wb_rd == rs1_f);
  assign wb_hit2    = wb_valid && (wb_rd == rs2_f);
  assign src1_stall = use_rs1 && (rs1_f != 5'd0) && busy_q[rs1_f] && !wb_hit1;
  assign src2_stall = use_rs2 && (rs2_f != 5'd0) && busy_q[rs2_f] && !wb_hit2;

  assign hazard = SB_EN && in_valid && (src1_stall || src2_stall);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic out_valid_q;
  logic accept;

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Busy next state: clear first so a same-index set on this edge wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != 5'd0)) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (accept && dec.rw) begin
      busy_d[dec.rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  bundle_t bundle_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      busy_q      <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        bundle_q    <= dec;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      busy_q <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1       = bundle_q.rs1;
  assign rs2       = bundle_q.rs2;
  assign rd        = bundle_q.rd;
  assign rw        = bundle_q.rw;
  assign imm       = bundle_q.imm;
  assign alu_op    = bundle_q.alu_op;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_c_decode_issue.sv
// ----------------------------------------------------------------------------
// tb_c_decode_issue
//
// Directed bench for c_decode_issue. Inputs change 1 ns after the rising edge;
// outputs are checked 1 ns after that, well away from the next edge. Expected
// values are hand-decoded from the instruction encodings.
// ----------------------------------------------------------------------------
module tb_c_decode_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        rw;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        illegal;
  logic        hazard;

  int checks   = 0;
  int failures = 0;

  c_decode_issue #(.SB_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .rw        (rw),
    .imm       (imm),
    .alu_op    (alu_op),
    .illegal   (illegal),
    .hazard    (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_rd",        {27'b0, rd},        32'd0);
    check("rst_rw",        {31'b0, rw},        32'd0);
    check("rst_imm",       imm,                32'd0);
    check("rst_alu_op",    {28'b0, alu_op},    32'd0);
    check("rst_illegal",   {31'b0, illegal},   32'd0);
    check("rst_busy",      dut.busy_q,         32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // addi x2,x0,50
    instr    = 32'h0320_0113;
    in_valid = 1'b1;
    #1;
    check("addi_hazard",   {31'b0, hazard},   32'd0);
    check("addi_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("addi_out_valid", {31'b0, out_valid}, 32'd1);
    check("addi_rd",        {27'b0, rd},        32'd2);
    check("addi_rs1",       {27'b0, rs1},       32'd0);
    check("addi_rw",        {31'b0, rw},        32'd1);
    check("addi_imm",       imm,                32'd50);
    check("addi_alu_op",    {28'b0, alu_op},    32'd0);
    check("addi_busy2",     {31'b0, dut.busy_q[2]}, 32'd1);

    // add x3,x2,x2 stalls on x2
    instr = 32'h0021_01B3;
    #1;
    check("add_hazard",   {31'b0, hazard},   32'd1);
    check("add_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("add_drain_out_valid", {31'b0, out_valid}, 32'd0);
    check("add_hazard_held",     {31'b0, hazard},    32'd1);
    check("add_in_ready_held",   {31'b0, in_ready},  32'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd2;
    #1;
    check("add_bypass_hazard",   {31'b0, hazard},   32'd0);
    check("add_bypass_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    check("add_out_valid", {31'b0, out_valid}, 32'd1);
    check("add_rd",        {27'b0, rd},        32'd3);
    check("add_rs1",       {27'b0, rs1},       32'd2);
    check("add_rs2",       {27'b0, rs2},       32'd2);
    check("add_rw",        {31'b0, rw},        32'd1);
    check("add_busy",      dut.busy_q,         32'h0000_0008);

    // sub x5,x6,x7
    instr = 32'h4073_02B3;
    #1;
    check("sub_hazard", {31'b0, hazard}, 32'd0);
    tick();
    check("sub_alu_op", {28'b0, alu_op}, 32'b1000);
    check("sub_rs1",    {27'b0, rs1},    32'd6);
    check("sub_rs2",    {27'b0, rs2},    32'd7);
    check("sub_rd",     {27'b0, rd},     32'd5);
    check("sub_rw",     {31'b0, rw},     32'd1);
    check("sub_imm",    imm,             32'd0);

    // Backpressure: srai x9,x1,3 waits while out_ready=0
    out_ready = 1'b0;
    instr     = 32'h4030_D493;
    #1;
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_rd",        {27'b0, rd},        32'd5);
      check("stall_alu_op",    {28'b0, alu_op},    32'b1000);
      check("stall_rs1",       {27'b0, rs1},       32'd6);
      check("stall_imm",       imm,                32'd0);
      check("stall_in_ready2", {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("srai_out_valid", {31'b0, out_valid}, 32'd1);
    check("srai_rd",        {27'b0, rd},        32'd9);
    check("srai_rs1",       {27'b0, rs1},       32'd1);
    check("srai_alu_op",    {28'b0, alu_op},    32'b1101);
    check("srai_imm",       imm,                32'h0000_0403);
    check("srai_rw",        {31'b0, rw},        32'd1);

    // Illegal opcodes
    instr = 32'h0000_007F;
    tick();
    check("ill_illegal", {31'b0, illegal}, 32'd1);
    check("ill_rw",      {31'b0, rw},      32'd0);
    check("ill_imm",     imm,              32'd0);
    check("ill_alu_op",  {28'b0, alu_op},  32'd0);
    check("ill_busy",    dut.busy_q,       32'h0000_0228);
    instr = 32'h0000_0FFF;
    tick();
    check("ill31_illegal", {31'b0, illegal}, 32'd1);
    check("ill31_rd",      {27'b0, rd},      32'd31);
    check("ill31_rw",      {31'b0, rw},      32'd0);
    check("ill31_busy",    dut.busy_q,       32'h0000_0228);

    // lui x0,0x12345
    instr = 32'h1234_5037;
    tick();
    check("lui0_rw",      {31'b0, rw},      32'd0);
    check("lui0_illegal", {31'b0, illegal}, 32'd0);
    check("lui0_imm",     imm,              32'h1234_5000);
    check("lui0_busy",    dut.busy_q,       32'h0000_0228);

    // lui x12,0x00028: rs1 field aliases busy x5 but LUI reads no source
    instr = 32'h0002_8637;
    #1;
    check("lui12_hazard", {31'b0, hazard}, 32'd0);
    tick();
    check("lui12_rw",   {31'b0, rw}, 32'd1);
    check("lui12_rd",   {27'b0, rd}, 32'd12);
    check("lui12_imm",  imm,         32'h0002_8000);
    check("lui12_busy", dut.busy_q,  32'h0000_1228);

    // sw x3,8(x4): stalls on rs2=x3 until the writeback bypass
    instr = 32'h0032_2423;
    #1;
    check("sw_hazard", {31'b0, hazard}, 32'd1);
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    #1;
    check("sw_bypass_hazard", {31'b0, hazard}, 32'd0);
    tick();
    wb_valid = 1'b0;
    check("sw_imm",    imm,             32'd8);
    check("sw_rw",     {31'b0, rw},     32'd0);
    check("sw_alu_op", {28'b0, alu_op}, 32'd0);
    check("sw_rs1",    {27'b0, rs1},    32'd4);
    check("sw_rs2",    {27'b0, rs2},    32'd3);
    check("sw_busy",   dut.busy_q,      32'h0000_1220);

    // lw x11,-4(x0)
    instr = 32'hFFC0_2583;
    tick();
    check("lw_imm",  imm,         32'hFFFF_FFFC);
    check("lw_rd",   {27'b0, rd}, 32'd11);
    check("lw_rw",   {31'b0, rw}, 32'd1);
    check("lw_busy", dut.busy_q,  32'h0000_1A20);

    // addi x7,x0,1 with a writeback to x7 on the same edge: set wins
    instr    = 32'h0010_0393;
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    tick();
    check("setclr_busy", dut.busy_q, 32'h0000_1AA0);

    // Plain writeback of x5, no accept: bundle drains
    in_valid = 1'b0;
    wb_rd    = 5'd5;
    tick();
    wb_valid = 1'b0;
    check("wb_busy",        dut.busy_q,         32'h0000_1A80);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // Mid-cycle reset with x2 and x3 busy
    in_valid = 1'b1;
    instr    = 32'h0320_0113;
    tick();
    instr    = 32'h0010_0193;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("prerst_busy23", {30'b0, dut.busy_q[3:2]}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_busy",      dut.busy_q,         32'd0);
    check("mid_rst_rd",        {27'b0, rd},        32'd0);
    check("mid_rst_rw",        {31'b0, rw},        32'd0);
    rst = 1'b1;
    #1;
    check("mid_rel_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h0021_01B3;
    #1;
    check("post_rst_hazard", {31'b0, hazard}, 32'd0);
    tick();
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_rd",        {27'b0, rd},        32'd3);
    check("post_rst_rs1",       {27'b0, rs1},       32'd2);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
